// File: rtl/vga_sync_receiver_if.sv
// Pixel-domain VGA link bundle: sync/RGB from the transmitter, regenerated timing and status to the consumer.
// master = link driver / capture consumer side, slave = receiver.
interface vga_sync_receiver_if;
    logic       hs_in;
    logic       vs_in;
    logic [5:0] rgb_in;
    logic [9:0] x;
    logic [8:0] y;
    logic       active;
    logic [5:0] pixel_out;
    logic       locked;
    logic       frame_start;
    logic       timing_err;

    modport master (
        output hs_in, vs_in, rgb_in,
        input  x, y, active, pixel_out, locked, frame_start, timing_err
    );

    modport slave (
        input  hs_in, vs_in, rgb_in,
        output x, y, active, pixel_out, locked, frame_start, timing_err
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA receive checker: regenerates x/y/active from hs/vs, verifies line/frame lengths, gates pixels on lock.
// Latency: rgb_in driven after edge N appears on pixel_out after edge N+2; no backpressure (free-running video).
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_sync_receiver_if.slave  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [8:0] Y_OFS    = 9'(V_SYNC + V_BP);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // stage 1: input capture
    logic       r_hs_q, r_hs_q_d;
    logic       r_vs_q, r_vs_q_d;
    logic [5:0] r_rgb_q;

    // timing counters
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_vs_pend;

    // lock FSM
    state_t     r_state, w_state_nxt;
    logic [3:0] r_good_cnt, w_good_cnt_nxt;
    logic       w_err;

    // stage 2: outputs
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic       r_active;
    logic [5:0] r_pixel;
    logic       r_frame_start;
    logic       r_timing_err;

    logic       w_hs_edge, w_vs_edge, w_v_rst;
    logic [9:0] w_h_inc, w_h_cur;
    logic [9:0] w_v_inc, w_v_cur;
    logic       w_line_bad, w_frame_bad, w_hs_lost;
    logic       w_h_vis, w_v_vis, w_lock_ok, w_act_nxt;
    logic [9:0] w_x;
    logic [8:0] w_y;
    logic [3:0] w_good_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_q   <= 1'b0;
            r_hs_q_d <= 1'b0;
            r_vs_q   <= 1'b0;
            r_vs_q_d <= 1'b0;
            r_rgb_q  <= '0;
        end else begin
            r_hs_q   <= bus.hs_in;
            r_hs_q_d <= r_hs_q;
            r_vs_q   <= bus.vs_in;
            r_vs_q_d <= r_vs_q;
            r_rgb_q  <= bus.rgb_in;
        end
    end

    assign w_hs_edge = !r_hs_q && r_hs_q_d;
    assign w_vs_edge = !r_vs_q && r_vs_q_d;

    // w_h_cur is the column of the pixel now in stage 1; r_h_cnt holds the previous cycle's column
    assign w_h_inc = (r_h_cnt == CNT_MAX) ? CNT_MAX : r_h_cnt + 10'd1;
    assign w_h_cur = w_hs_edge ? 10'd0 : w_h_inc;

    assign w_v_rst = w_hs_edge && (r_vs_pend || w_vs_edge);
    assign w_v_inc = (r_v_cnt == CNT_MAX) ? CNT_MAX : r_v_cnt + 10'd1;
    assign w_v_cur = w_v_rst   ? 10'd0 :
                     w_hs_edge ? w_v_inc : r_v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_vs_pend <= 1'b0;
        end else begin
            r_h_cnt   <= w_h_cur;
            r_v_cnt   <= w_v_cur;
            r_vs_pend <= (r_vs_pend || w_vs_edge) && !w_hs_edge;
        end
    end

    assign w_line_bad  = w_hs_edge && (r_h_cnt != H_LAST);
    assign w_frame_bad = (r_v_cnt != V_LAST);
    assign w_hs_lost   = (w_h_cur == CNT_MAX);
    assign w_good_inc  = r_good_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_err          = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                w_good_cnt_nxt = '0;
                if (w_v_rst) begin
                    w_state_nxt = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (w_line_bad || (w_v_rst && w_frame_bad)) begin
                    w_state_nxt    = ST_UNLOCKED;
                    w_good_cnt_nxt = '0;
                end else if (w_v_rst) begin
                    w_good_cnt_nxt = w_good_inc;
                    if (w_good_inc >= LOCK_N) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_line_bad || (w_v_rst && w_frame_bad) || w_hs_lost) begin
                    w_err          = 1'b1;
                    w_state_nxt    = ST_UNLOCKED;
                    w_good_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_UNLOCKED;
                w_good_cnt_nxt = '0;
            end
        endcase
    end

    // the cycle that raises timing_err must already present no pixel
    assign w_h_vis   = (w_h_cur >= H_VIS_LO) && (w_h_cur < H_VIS_HI);
    assign w_v_vis   = (w_v_cur >= V_VIS_LO) && (w_v_cur < V_VIS_HI);
    assign w_lock_ok = (r_state == ST_LOCKED) && !w_err;
    assign w_act_nxt = w_h_vis && w_v_vis && w_lock_ok;
    assign w_x       = w_h_cur - H_VIS_LO;
    assign w_y       = w_v_cur[8:0] - Y_OFS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b0;
            r_pixel       <= '0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
        end else begin
            if (w_act_nxt) begin
                r_x <= w_x;
                r_y <= w_y;
            end
            r_active      <= w_act_nxt;
            r_pixel       <= w_act_nxt ? r_rgb_q : 6'd0;
            r_frame_start <= w_act_nxt && (w_x == 10'd0) && (w_y == 9'd0);
            r_timing_err  <= w_err;
        end
    end

    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.active      = r_active;
    assign bus.pixel_out   = r_pixel;
    assign bus.locked      = (r_state == ST_LOCKED);
    assign bus.frame_start = r_frame_start;
    assign bus.timing_err  = r_timing_err;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 16x7 raster (8x3 visible) driven by an in-bench timing generator.
module tb_vga_sync_receiver;

    localparam int H_ACT = 8,  H_FP = 2, H_SYN = 3, H_BP = 3;
    localparam int V_ACT = 3,  V_FP = 1, V_SYN = 1, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;   // 16
    localparam int HVS   = H_SYN + H_BP;                  // 6
    localparam int VVS   = V_SYN + V_BP;                  // 3
    localparam logic [5:0] CONST_RGB = 6'b011011;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_sync_receiver_if intf();

    vga_sync_receiver #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
        .LOCK_FRAMES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf)
    );

    int checks   = 0;
    int failures = 0;
    int k        = 0;
    int act_cnt, fs_cnt, err_cnt, mon_bad;
    int lock_at, unlock_at, err_at, fs_at;
    int base;
    bit lk_prev  = 1'b0;
    bit pat_mode = 1'b0;
    int d_h = -100, d_v = -100;
    bit d_vis = 1'b0;
    logic [5:0] d_rgb = 6'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        act_cnt = 0; fs_cnt = 0; err_cnt = 0; mon_bad = 0;
        lock_at = -1; unlock_at = -1; err_at = -1; fs_at = -1;
    endtask

    // Drive one pixel clock at generator position (ph,pv), then inspect the outputs
    // against the pixel driven one step earlier (two edges of pipeline).
    task automatic step(input int ph, input int pv);
        bit         g_vis;
        logic [5:0] g_rgb;
        g_vis = (ph >= HVS) && (ph < HVS + H_ACT) && (pv >= VVS) && (pv < VVS + V_ACT);
        g_rgb = pat_mode ? 6'(ph - HVS) : CONST_RGB;
        intf.hs_in  = (ph >= 0 && ph < H_SYN) ? 1'b0 : 1'b1;
        intf.vs_in  = (pv >= 0 && pv < V_SYN) ? 1'b0 : 1'b1;
        intf.rgb_in = g_rgb;
        @(posedge clk);
        #1;
        if (intf.active === 1'b1) begin
            act_cnt++;
            if (!d_vis || intf.x !== 10'(d_h - HVS) || intf.y !== 9'(d_v - VVS) ||
                intf.pixel_out !== d_rgb)
                mon_bad++;
        end else if (intf.pixel_out !== 6'd0) begin
            mon_bad++;
        end
        if (intf.frame_start === 1'b1) begin
            fs_cnt++;
            fs_at = k;
            if (!(intf.active === 1'b1 && intf.x === 10'd0 && intf.y === 9'd0)) mon_bad++;
        end
        if (intf.timing_err === 1'b1) begin
            err_cnt++;
            err_at = k;
            if (intf.locked !== 1'b0 || intf.active !== 1'b0) mon_bad++;
        end
        if (intf.locked === 1'b1 && !lk_prev) lock_at = k;
        if (intf.locked !== 1'b1 && lk_prev) unlock_at = k;
        lk_prev = (intf.locked === 1'b1);
        d_h = ph; d_v = pv; d_vis = g_vis; d_rgb = g_rgb;
        k++;
    endtask

    task automatic run_line(input int v, input int len);
        for (int h = 0; h < len; h++) step(h, v);
    endtask

    task automatic run_frame(input int nlines);
        for (int v = 0; v < nlines; v++) run_line(v, H_TOT);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_x"},           32'(intf.x),           32'd0);
        chk({pfx, "_y"},           32'(intf.y),           32'd0);
        chk({pfx, "_active"},      32'(intf.active),      32'd0);
        chk({pfx, "_pixel_out"},   32'(intf.pixel_out),   32'd0);
        chk({pfx, "_locked"},      32'(intf.locked),      32'd0);
        chk({pfx, "_frame_start"}, 32'(intf.frame_start), 32'd0);
        chk({pfx, "_timing_err"},  32'(intf.timing_err),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        intf.hs_in = 1'b1; intf.vs_in = 1'b1; intf.rgb_in = 6'd0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) step(-100, -100);

        // nominal acquisition with constant colour; frame 1 starts at k=0
        k = 0;
        clr();
        run_frame(V_ACT + V_FP + V_SYN + V_BP);
        run_frame(7);
        chk("acq_locked_before_f3", 32'(intf.locked), 32'd0);
        chk("acq_active_cnt",       32'(act_cnt),     32'd0);
        run_frame(7);
        chk("lock_rise_step",       32'(lock_at),     32'd225);
        chk("first_fs_step",        32'(fs_at),       32'd279);
        chk("f3_fs_cnt",            32'(fs_cnt),      32'd1);
        chk("f3_active_cnt",        32'(act_cnt),     32'd24);
        chk("f3_pixel_mon",         32'(mon_bad),     32'd0);
        chk("f3_err_cnt",           32'(err_cnt),     32'd0);

        // x-pattern colour checks pixel/x alignment
        pat_mode = 1'b1;
        clr();
        run_frame(7);
        run_frame(7);
        chk("pat_active_cnt", 32'(act_cnt),     32'd48);
        chk("pat_fs_cnt",     32'(fs_cnt),      32'd2);
        chk("pat_pixel_mon",  32'(mon_bad),     32'd0);
        chk("pat_err_cnt",    32'(err_cnt),     32'd0);
        chk("pat_locked",     32'(intf.locked), 32'd1);

        // line 4 shortened by one pixel while locked
        clr();
        base = k;
        for (int v = 0; v < 4; v++) run_line(v, H_TOT);
        run_line(4, H_TOT - 1);
        run_line(5, H_TOT);
        run_line(6, H_TOT);
        chk("short_err_step",    32'(err_at),      32'(base + 80));
        chk("short_unlock_step", 32'(unlock_at),   32'(base + 80));
        chk("short_err_cnt",     32'(err_cnt),     32'd1);
        chk("short_active_cnt",  32'(act_cnt),     32'd16);
        chk("short_mon",         32'(mon_bad),     32'd0);
        chk("short_locked",      32'(intf.locked), 32'd0);
        clr();
        base = k;
        run_frame(7); run_frame(7); run_frame(7);
        chk("relock1_step",      32'(lock_at),     32'(base + 225));
        chk("relock1_err_cnt",   32'(err_cnt),     32'd0);

        // hs held high for 1100 cycles while locked
        clr();
        base = k;
        for (int v = 0; v < 4; v++) run_line(v, H_TOT);
        run_line(4, 1100);
        run_line(5, H_TOT);
        run_line(6, H_TOT);
        chk("hslost_err_step",   32'(err_at),      32'(base + 1088));
        chk("hslost_unlock",     32'(unlock_at),   32'(base + 1088));
        chk("hslost_err_cnt",    32'(err_cnt),     32'd1);
        chk("hslost_active_cnt", 32'(act_cnt),     32'd16);
        chk("hslost_locked",     32'(intf.locked), 32'd0);

        // 6-line frame during acquisition drops back without an error pulse
        clr();
        run_frame(6);
        run_frame(7);
        chk("short_frame_locked",  32'(intf.locked), 32'd0);
        base = k;
        run_frame(7); run_frame(7); run_frame(7);
        chk("short_frame_lock_step", 32'(lock_at),   32'(base + 225));
        chk("short_frame_err_cnt",   32'(err_cnt),   32'd0);
        chk("short_frame_mon",       32'(mon_bad),   32'd0);

        // asynchronous reset mid visible line while locked
        clr();
        for (int v = 0; v < 4; v++) run_line(v, H_TOT);
        for (int h = 0; h < 10; h++) step(h, 4);
        chk("prerst_active", 32'(intf.active), 32'd1);
        chk("prerst_x",      32'(intf.x),      32'd2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step(10, 4); step(11, 4); step(12, 4);
        rst_n = 1'b1;
        for (int h = 13; h < H_TOT; h++) step(h, 4);
        run_line(5, H_TOT);
        run_line(6, H_TOT);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        clr();
        base = k;
        run_frame(7); run_frame(7); run_frame(7);
        chk("relock_rst_step", 32'(lock_at),  32'(base + 225));
        chk("relock_rst_fs",   32'(fs_cnt),   32'd1);
        chk("relock_rst_mon",  32'(mon_bad),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive side of the 640x480 VGA link driven by our timing generator: samples hs/vs and 6-bit RGB in the pixel-clock domain, regenerates x/y/active, and verifies line and frame lengths against nominal timing. Used as a loopback checker on the FPGA bench and as the front end of a frame-capture path. Reports lock status and timing errors, and presents only pixels captured while locked.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk  in  1  pixel clock, same domain as the transmitter
- rst_n  in  1  reset, asynchronous, active-low
- hs_in  in  1  horizontal sync, active-low
- vs_in  in  1  vertical sync, active-low
- rgb_in  in  6  {r[1:0], g[1:0], b[1:0]}
- x  out  10  column of pixel_out, 0..H_ACTIVE-1
- y  out  9  row of pixel_out, 0..V_ACTIVE-1
- active  out  1  pixel_out valid (in visible area and locked)
- pixel_out  out  6  captured RGB; 0 when active=0
- locked  out  1  timing lock achieved
- frame_start  out  1  one-cycle pulse with x=0,y=0 while locked
- timing_err  out  1  one-cycle pulse on any mismatch while locked

## Operation
- Stage 1: register hs_in, vs_in, rgb_in (hs_q, vs_q, rgb_q); keep hs_q_d, vs_q_d.
- HS edge: hs_q=0 and hs_q_d=1. On HS edge h_cnt<=0, else h_cnt+1 (10-bit, saturate at 1023).
- Line check at HS edge: previous h_cnt must equal H_TOTAL-1 (H_TOTAL=800); otherwise line bad.
- VS edge: vs_q=0 and vs_q_d=1; sets vs_pend. On next HS edge (or same cycle) v_cnt<=0 and vs_pend cleared; other HS edges v_cnt+1 (10-bit, saturate). Frame check at the v_cnt reset: previous v_cnt must equal V_TOTAL-1 (V_TOTAL=525).
- Visible: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) = [144,784), v_cnt in [V_SYNC+V_BP, +V_ACTIVE) = [35,515). x=h_cnt-144, y=v_cnt-35.
- FSM:
  - UNLOCKED: locked=0, good_cnt=0. First VS-aligned v_cnt reset -> ACQUIRE.
  - ACQUIRE: any bad line -> UNLOCKED. Good frame end -> good_cnt+1; reaching LOCK_FRAMES -> LOCKED. Bad frame -> UNLOCKED.
  - LOCKED: bad line, bad frame, or h_cnt reaching 1023 (hs lost) -> timing_err pulse, UNLOCKED.
- active, x, y, pixel_out, frame_start registered together (stage 2); x/y hold last value when active=0.

## Timing
- Reset: x=0, y=0, active=0, pixel_out=0, locked=0, frame_start=0, timing_err=0, state UNLOCKED, counters 0, vs_pend=0.
- Latency: rgb_in at clock edge N appears on pixel_out after edge N+2; x/y/active describe that same pixel.
- h_cnt=0 is the first cycle hs_q reads low; pixel x=0 is sampled 144 cycles after hs_in falls.
- locked rises on the cycle after the v_cnt reset that completes the LOCK_FRAMES-th good frame. The first frame_start follows in the same frame, 35 lines later.
- Error in LOCKED: timing_err and the fall of locked occur on the same edge. active drops on that edge, and no further pixel_out is valid.
- VS edge and HS edge in the same cycle: treated as aligned; v_cnt<=0 on that cycle.
- rst_n assertion mid-frame clears all state immediately. After release, the receiver relocks from UNLOCKED.

## Test plan
- Nominal loopback from vga_timing_gen, constant rgb 6'b011011 -> locked=1 after 2 full frames post first vsync. active high for exactly 640x480 cycles per frame, pixel_out=6'b011011 throughout.
- Pattern rgb_in = x[5:0] from the generator -> pixel_out equals reported x[5:0] every active cycle (verifies 2-cycle alignment). frame_start once per 420000 cycles.
- While locked, shorten one line to 799 cycles -> timing_err pulse at next hs edge, locked=0, active=0. Relock after 2 good frames.
- Frame of 524 lines in ACQUIRE -> back to UNLOCKED, no timing_err, locked stays 0.
- hs_in held high for 1100 cycles while locked -> timing_err when h_cnt hits 1023, locked=0.
- rst_n pulsed low for 3 cycles mid-active-line -> all outputs 0 asynchronously. Normal lock reacquired 2 frames after next vsync.
